// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU issue definitions (package alu_pkg): operand modes, alucontrol codes, FSM states.
// Also provides is_mul_class(), which decides which operations take the long EXEC latency.
package alu_pkg;

    localparam logic [1:0] MODE_R4 = 2'b00;
    localparam logic [1:0] MODE_R3 = 2'b01;
    localparam logic [1:0] MODE_R2 = 2'b10;
    localparam logic [1:0] MODE_I  = 2'b11;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_XOR = 5'b00100;
    localparam logic [4:0] ALU_SLT = 5'b00101;
    localparam logic [4:0] ALU_MAC = 5'b01110;
    localparam logic [4:0] ALU_MSC = 5'b01111;
    localparam logic [4:0] ALU_MUL = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

    // MAC/MSC exist only as R4 ops and MUL only as an R3 op; same codes in other modes are single-cycle.
    function automatic logic is_mul_class(input logic [1:0] mode, input logic [4:0] ctrl);
        return ((mode == MODE_R4) && ((ctrl == ALU_MAC) || (ctrl == ALU_MSC))) ||
               ((mode == MODE_R3) && (ctrl == ALU_MUL));
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle for alu_issue_ctrl: two request channels, the ALU operand/result path,
// the response channel and debug visibility (FSM state, last grant).
interface alu_issue_ctrl_if #(
    parameter int XLEN = 32
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, is held with stable payload until that transfer.
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [XLEN-1:0] req0_c;
    logic [4:0]      req0_ctrl;
    logic [1:0]      req0_mode;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [XLEN-1:0] req1_c;
    logic [4:0]      req1_ctrl;
    logic [1:0]      req1_mode;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_c;
    logic [4:0]      alu_ctrl;
    logic [1:0]      alu_mode;
    logic [XLEN-1:0] alu_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;

    logic            busy;
    alu_pkg::alu_state_e state;
    logic            last_grant;

    modport master (
        output req0_valid, req0_a, req0_b, req0_c, req0_ctrl, req0_mode,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_c, req1_ctrl, req1_mode,
        input  req1_ready,
        input  alu_a, alu_b, alu_c, alu_ctrl, alu_mode,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready,
        input  busy, state, last_grant
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c, req0_ctrl, req0_mode,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_c, req1_ctrl, req1_mode,
        output req1_ready,
        output alu_a, alu_b, alu_c, alu_ctrl, alu_mode,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready,
        output busy, state, last_grant
    );

endinterface

// File: rtl/alu_issue_ctrl_arb.sv
// alu_rr_arb: two-way grant for the shared ALU. Round-robin when ALU_ISSUE_RR_EN is defined,
// otherwise fixed priority with req[0] winning.
module alu_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic       grant_valid,
    output logic       grant,
    output logic       last_grant
);

    always_comb begin
        grant = req[1] & ~req[0];
`ifdef ALU_ISSUE_RR_EN
        // Reset value 1 makes the first contention go to requester 0.
        if (req == 2'b11) begin
            grant = ~last_grant;
        end
`else
        if (req == 2'b11) begin
            grant = 1'b0;
        end
`endif
    end

    assign grant_valid = en & (|req);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller sharing one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Arbitration policy is selected by the ALU_ISSUE_RR_EN macro (undefined: fixed priority to req0).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input logic           clk,
    input logic           rst,
    alu_issue_ctrl_if.slave bus
);

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    alu_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            op_id;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] c_q;
    logic [4:0]      ctrl_q;
    logic [1:0]      mode_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [XLEN-1:0] rsp_result_q;
    logic            rsp_zero_q;

    logic            grant_valid;
    logic            grant;
    logic            last_grant;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [XLEN-1:0] sel_c;
    logic [4:0]      sel_ctrl;
    logic [1:0]      sel_mode;
    logic            sel_mul;

    // Gated by rst so a requester never sees a transfer that reset would drop.
    alu_rr_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         ({bus.req1_valid, bus.req0_valid}),
        .en          ((state == ST_IDLE) && !rst),
        .grant_valid (grant_valid),
        .grant       (grant),
        .last_grant  (last_grant)
    );

    assign bus.req0_ready = grant_valid & ~grant;
    assign bus.req1_ready = grant_valid & grant;

    always_comb begin
        sel_a    = bus.req0_a;
        sel_b    = bus.req0_b;
        sel_c    = bus.req0_c;
        sel_ctrl = bus.req0_ctrl;
        sel_mode = bus.req0_mode;
        if (grant) begin
            sel_a    = bus.req1_a;
            sel_b    = bus.req1_b;
            sel_c    = bus.req1_c;
            sel_ctrl = bus.req1_ctrl;
            sel_mode = bus.req1_mode;
        end
        sel_mul = is_mul_class(sel_mode, sel_ctrl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_id        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            ctrl_q       <= '0;
            mode_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        c_q    <= sel_c;
                        ctrl_q <= sel_ctrl;
                        mode_q <= sel_mode;
                        op_id  <= grant;
                        cnt    <= sel_mul ? MUL_CNT : '0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // cnt counts the remaining EXEC cycles after this one.
                    if (cnt == '0) begin
                        rsp_result_q <= bus.alu_result;
                        rsp_zero_q   <= (bus.alu_result == '0);
                        rsp_id_q     <= op_id;
                        rsp_valid_q  <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_c      = c_q;
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.alu_mode   = mode_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.state      = state;
    assign bus.last_grant = last_grant;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller that shares the single combinational ALU between two requesters (integer pipe = req0, co-processor/loop unit = req1). It arbitrates, latches one operation, holds the ALU operands stable for the operation's latency, captures the result and zero flag, and returns them over a valid/ready response channel tagged with the requester ID. Sits between the decode/issue stages and the ALU instance.

## Interface
Parameters:
- XLEN, 32, operand/result width
- MUL_LAT, 3, EXEC cycles for multiply-class ops (legal range 1..15)

Ports (clock is `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- reqN_a, reqN_b, reqN_c  in  XLEN  operands SrcA/SrcB/SrcC
- reqN_ctrl  in  5  alucontrol code
- reqN_mode  in  2  mode (00 R4, 01 R3, 10 R2, 11 I)
- alu_a, alu_b, alu_c  out  XLEN  to ALU SrcA/SrcB/SrcC
- alu_ctrl  out  5, alu_mode  out  2  to ALU
- alu_result  in  XLEN  from ALU Result
- rsp_valid  out  1, rsp_ready  in  1  response handshake
- rsp_id  out  1  requester of this response
- rsp_result  out  XLEN, rsp_zero  out  1  (result == 0)
- busy  out  1  state != IDLE

## Operation
- FSM states IDLE, EXEC, RESP.
- IDLE: if either valid, select grant; assert that requester's ready combinationally in the same cycle; latch a/b/c/ctrl/mode/id; load cnt = lat-1; go EXEC. Ready is never asserted outside IDLE, and never to both requesters.
- lat = MUL_LAT for multiply-class ops (mode 00 with ctrl 01110 or 01111; mode 01 with ctrl 11111), else 1.
- EXEC: alu_* driven from latched regs. If cnt == 0: capture alu_result into rsp_result, rsp_zero = (alu_result == 0), go RESP; else cnt decrements.
- RESP: rsp_valid = 1, outputs stable until rsp_ready; on rsp_valid & rsp_ready go IDLE. A request arriving during EXEC/RESP waits (valid held by requester).
- alu_* outputs hold their latched values in all states (no X driven to the ALU).
- Arbitration: see Configuration. last_grant updates only on acceptance.
- Result is passed through unmodified; no width extension or saturation.
- rst mid-operation: in-flight op discarded, no response issued, FSM to IDLE.
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, busy 0, alu_* 0, last_grant 1, cnt 0.

## Timing
- Accept at cycle T -> EXEC T+1..T+lat -> rsp_valid at T+lat+1.
- Single-cycle op: rsp_valid at T+2; multiply-class with MUL_LAT=3: T+4.
- Minimum issue interval lat+2 cycles (RESP -> IDLE costs one cycle even with rsp_ready high).
- rsp_ready low stalls in RESP indefinitely; no data loss.

## Configuration
- ALU_ISSUE_RR_EN defined: round-robin; when both valid, grant the requester not granted last; first contention after reset goes to req0.
- Not defined: fixed priority, req0 always wins; req1 served only when req0_valid is low in IDLE.

## Structure
- Shared package `alu_pkg`: mode encodings (MODE_R4/R3/R2/I), alucontrol code constants (MAC, MSC, MUL, ADD, ...), FSM state enum, function `is_mul_class(mode, ctrl)`.
- One sub-module natural: `alu_rr_arb` (2-way arbiter, grant + last_grant, macro-controlled policy).

## Test plan
- req0 R3 add (mode 01, ctrl 00000, a=5, b=7) -> req0_ready at T, rsp_valid at T+2, rsp_result=12, rsp_zero=0, rsp_id=0.
- req1 R4 mac (mode 00, ctrl 01110, a=3, b=4, c=5), MUL_LAT=3 -> rsp_valid at T+4, rsp_result=17, alu_* stable T+1..T+3.
- Both valid continuously, RR_EN defined -> grants alternate 0,1,0,1; undefined -> only req0 served while its valid is high.
- R3 xor a=b=0xA5A5A5A5 -> rsp_result=0, rsp_zero=1; hold rsp_ready low 5 cycles -> rsp outputs stable, no ready to requesters.
- rst asserted during EXEC of a mul -> next cycle busy=0, rsp_valid=0, no response for that op; next request accepted normally.
